rf_stream_reader: RTL and testbench

- Reader-side engine for the dual-port register file: walks a contiguous address window and streams the entries out on a valid/ready interface.
- Drives the register file's read port (rd, rdAddr) and consumes its combinational dataOut. The register file has zero read latency, so data is captured on the same edge the address is issued.
- Sits between a register file and a downstream consumer, such as a PE operand bus or memory writeback. A 2-entry output buffer gives full throughput under backpressure.

---
 rtl/rf_reader_pkg.sv | 22 ++
 rtl/rf_stream_reader_if.sv | 41 ++++
 rtl/rf_skid_buffer.sv | 70 +++++++
 rtl/rf_stream_reader.sv | 104 ++++++++++
 tb/tb_rf_stream_reader.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_reader_pkg.sv
// Shared types and constants for the register-file stream reader:
// FSM state encoding, counter width helper and output buffer depth.
package rf_reader_pkg;

    localparam int RF_ADDR_LEN = 5;
    localparam int RF_DATA_LEN = 32;
    localparam int RF_CNT_LEN  = RF_ADDR_LEN + 1;
    localparam int BUF_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The remaining counter must hold the full depth, hence one extra bit.
    function automatic int cntLen(input int addrLen);
        return addrLen + 1;
    endfunction

endpackage

// File: rtl/rf_stream_reader_if.sv
// Register-file read port plus output valid/ready stream of the reader.
// RF_READER_CLEAR_EN adds the clear-on-read write port.
interface rf_stream_reader_if #(
    parameter int ADDR_LEN = 5,
    parameter int DATA_LEN = 32
) ();

    logic                rfRd;
    logic [ADDR_LEN-1:0] rfRdAddr;
    logic [DATA_LEN-1:0] rfDataIn;
    logic                outValid;
    logic                outReady;
    logic [DATA_LEN-1:0] outData;

`ifdef RF_READER_CLEAR_EN
    logic                rfWrt;
    logic [ADDR_LEN-1:0] rfWrtAddr;
    logic [DATA_LEN-1:0] rfWrtData;

    modport master (
        output rfRd, rfRdAddr, outValid, outData, rfWrt, rfWrtAddr, rfWrtData,
        input  rfDataIn, outReady
    );

    modport slave (
        input  rfRd, rfRdAddr, outValid, outData, rfWrt, rfWrtAddr, rfWrtData,
        output rfDataIn, outReady
    );
`else
    modport master (
        output rfRd, rfRdAddr, outValid, outData,
        input  rfDataIn, outReady
    );

    modport slave (
        input  rfRd, rfRdAddr, outValid, outData,
        output rfDataIn, outReady
    );
`endif

endinterface

// File: rtl/rf_skid_buffer.sv
// Two-entry valid/ready output buffer; the head entry drives the output
// register directly and a free flag tells the producer it may push.
module rf_skid_buffer
    import rf_reader_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [DATA_LEN-1:0] pushData,
    input  logic                ready,
    output logic                valid,
    output logic [DATA_LEN-1:0] data,
    output logic                free,
    output logic                empty
);

    logic [1:0]          r_cnt;
    logic [DATA_LEN-1:0] r_head;
    logic [DATA_LEN-1:0] r_tail;
    logic                w_pop;
    logic                w_push;

    assign w_pop  = (r_cnt != 2'd0) && ready;
    // A slot counts as free when one is empty or the head leaves this cycle.
    assign free   = (r_cnt != 2'(BUF_DEPTH)) || w_pop;
    assign w_push = push && free;
    assign empty  = (r_cnt == 2'd0);
    assign valid  = !empty;
    assign data   = r_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_head <= pushData;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= pushData;
                    end else if (w_push) begin
                        r_tail <= pushData;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= pushData;
                        end else begin
                            r_cnt  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rf_stream_reader.sv
// Walks a contiguous register-file window and streams the words out through
// a 2-entry buffer. RF_READER_CLEAR_EN zeroes each entry as it is read.
module rf_stream_reader
    import rf_reader_pkg::*;
#(
    parameter  int ADDR_LEN = 5,
    parameter  int DATA_LEN = 32,
    localparam int CNT_LEN  = cntLen(ADDR_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] baseAddr,
    input  logic [CNT_LEN-1:0]  count,
    output logic                busy,
    output logic                done,
    rf_stream_reader_if.master  bus
);

    state_t              r_state;
    logic [ADDR_LEN-1:0] r_ptr;
    logic [CNT_LEN-1:0]  r_rem;
    logic                r_busy;
    logic                r_done;
    logic                w_free;
    logic                w_empty;
    logic                w_rd;

    // Zero-latency RF: the word for r_ptr is captured on the same edge.
    assign w_rd         = (r_state == READ) && w_free;
    assign bus.rfRd     = w_rd;
    assign bus.rfRdAddr = r_ptr;
    assign busy         = r_busy;
    assign done         = r_done;

`ifdef RF_READER_CLEAR_EN
    assign bus.rfWrt     = w_rd;
    assign bus.rfWrtAddr = r_ptr;
    assign bus.rfWrtData = '0;
`endif

    rf_skid_buffer #(
        .DATA_LEN (DATA_LEN)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (w_rd),
        .pushData (bus.rfDataIn),
        .ready    (bus.outReady),
        .valid    (bus.outValid),
        .data     (bus.outData),
        .free     (w_free),
        .empty    (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr  <= baseAddr;
                        r_rem  <= count;
                        r_busy <= 1'b1;
                        // An empty window finishes at once, busy covering the done cycle.
                        if (count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    if (w_rd) begin
                        r_ptr <= r_ptr + ADDR_LEN'(1);
                        r_rem <= r_rem - CNT_LEN'(1);
                        if (r_rem == CNT_LEN'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_stream_reader.sv
// Directed bench for rf_stream_reader with a behavioural register file.
// Define RF_READER_CLEAR_EN to also exercise clear-on-read.
module tb_rf_stream_reader;

    localparam int AL = 5;
    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AL-1:0] baseAddr = '0;
    logic [AL:0]   count = '0;
    logic          busy;
    logic          done;
    logic          outReady = 1'b0;
    logic          preloadReq = 1'b0;
    logic [DL-1:0] rfMem [32];

    int errors = 0;
    int checks = 0;

    // Results gathered by runStream for the scenario tasks to judge.
    int            rdAddrQ[$];
    int            rdCycleQ[$];
    logic [DL-1:0] dataQ[$];
    int            firstValid;
    int            doneCycle;
    int            doneCount;
    int            stableViol;
    int            bufViol;
    int            wrtViol;
    logic          busyAt1;
    logic          busyAtDone;

    always #5 clk = ~clk;

    rf_stream_reader_if #(.ADDR_LEN(AL), .DATA_LEN(DL)) bus ();

    rf_stream_reader #(.ADDR_LEN(AL), .DATA_LEN(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .baseAddr (baseAddr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    assign bus.rfDataIn = rfMem[bus.rfRdAddr];
    assign bus.outReady = outReady;

    always @(posedge clk) begin
        if (preloadReq) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= DL'(i + 32'h100);
        end
`ifdef RF_READER_CLEAR_EN
        else if (bus.rfWrt) begin
            rfMem[bus.rfWrtAddr] <= bus.rfWrtData;
        end
`endif
    end

    function automatic logic [DL-1:0] expData(input int addr);
        return DL'((addr % 32) + 32'h100);
    endfunction

    task automatic preload();
        @(negedge clk);
        preloadReq = 1'b1;
        @(negedge clk);
        preloadReq = 1'b0;
    endtask

    // Launches one transfer and monitors it cycle by cycle; cycle 0 is the
    // start cycle. readyMode 0 holds outReady high, 1 uses the pattern 1,0,0.
    task automatic runStream(input logic [AL-1:0] b, input logic [AL:0] n,
                             input int readyMode, input int injectAt, input int maxCycles);
        int            occ;
        logic          prevStall;
        logic [DL-1:0] prevData;
        logic          hs;
        rdAddrQ.delete();
        rdCycleQ.delete();
        dataQ.delete();
        firstValid = -1;
        doneCycle  = -1;
        doneCount  = 0;
        stableViol = 0;
        bufViol    = 0;
        wrtViol    = 0;
        busyAt1    = 1'b0;
        busyAtDone = 1'b1;
        occ        = 0;
        prevStall  = 1'b0;
        prevData   = '0;
        @(negedge clk);
        start    = 1'b1;
        baseAddr = b;
        count    = n;
        outReady = 1'b1;
        for (int c = 1; c <= maxCycles; c++) begin
            @(negedge clk);
            start = (c == injectAt);
            if (c == injectAt) begin
                baseAddr = 5'd20;
                count    = 6'd1;
            end
            outReady = (readyMode == 0) ? 1'b1 : ((c % 3) == 1);
            #1;
            if (c == 1) busyAt1 = busy;
            hs = bus.outValid && outReady;
            if (prevStall && (!bus.outValid || bus.outData !== prevData)) stableViol++;
            if (bus.outValid !== (occ > 0)) bufViol++;
            if (bus.rfRd) begin
                rdAddrQ.push_back(int'(bus.rfRdAddr));
                rdCycleQ.push_back(c);
                if (occ >= 2 && !hs) bufViol++;
            end
`ifdef RF_READER_CLEAR_EN
            if (bus.rfWrt !== bus.rfRd) wrtViol++;
            if (bus.rfRd && (bus.rfWrtAddr !== bus.rfRdAddr || bus.rfWrtData !== '0)) wrtViol++;
`endif
            if (bus.outValid && firstValid < 0) firstValid = c;
            if (hs) dataQ.push_back(bus.outData);
            if (done) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle  = c;
                    busyAtDone = busy;
                end
            end
            occ = occ + (bus.rfRd ? 1 : 0) - (hs ? 1 : 0);
            prevStall = bus.outValid && !outReady;
            prevData  = bus.outData;
            if (doneCycle >= 0 && c >= doneCycle + 2) break;
        end
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        outReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
        checks++; if (bus.rfRd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rfRd got=%0b want=0", bus.rfRd); end
        checks++; if (bus.rfRdAddr !== '0) begin errors++; $display("[TB] FAIL reset_rfRdAddr got=%0d want=0", bus.rfRdAddr); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid got=%0b want=0", bus.outValid); end
        checks++; if (bus.outData !== '0) begin errors++; $display("[TB] FAIL reset_outData got=%h want=0", bus.outData); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_basic();
        runStream(5'd4, 6'd3, 0, 0, 40);
        checks++; if (rdAddrQ.size() !== 3) begin errors++; $display("[TB] FAIL basic_reads got=%0d want=3", rdAddrQ.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rdAddrQ.size() || rdAddrQ[i] !== 4 + i || rdCycleQ[i] !== 1 + i) begin
                errors++;
                $display("[TB] FAIL basic_rd%0d got addr=%0d cyc=%0d want addr=%0d cyc=%0d", i,
                         (i < rdAddrQ.size()) ? rdAddrQ[i] : -1, (i < rdCycleQ.size()) ? rdCycleQ[i] : -1, 4 + i, 1 + i);
            end
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(4 + i)) begin
                errors++;
                $display("[TB] FAIL basic_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(4 + i));
            end
        end
        checks++; if (dataQ.size() !== 3) begin errors++; $display("[TB] FAIL basic_words got=%0d want=3", dataQ.size()); end
        checks++; if (firstValid !== 2) begin errors++; $display("[TB] FAIL basic_latency got=%0d want=2", firstValid); end
        checks++; if (doneCycle !== 6) begin errors++; $display("[TB] FAIL basic_done got=%0d want=6", doneCycle); end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL basic_done_width got=%0d want=1", doneCount); end
        checks++; if (busyAt1 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got=%0b want=1", busyAt1); end
        checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done got=%0b want=0", busyAtDone); end
    endtask

    task automatic test_wrap();
        int want [4] = '{30, 31, 0, 1};
        runStream(5'd30, 6'd4, 0, 0, 40);
        checks++; if (dataQ.size() !== 4) begin errors++; $display("[TB] FAIL wrap_words got=%0d want=4", dataQ.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rdAddrQ.size() || rdAddrQ[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL wrap_addr%0d got=%0d want=%0d", i, (i < rdAddrQ.size()) ? rdAddrQ[i] : -1, want[i]);
            end
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(want[i])) begin
                errors++;
                $display("[TB] FAIL wrap_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(want[i]));
            end
        end
        checks++; if (doneCycle !== 7) begin errors++; $display("[TB] FAIL wrap_done got=%0d want=7", doneCycle); end
    endtask

    task automatic test_backpressure();
        runStream(5'd10, 6'd8, 1, 0, 100);
        checks++; if (dataQ.size() !== 8) begin errors++; $display("[TB] FAIL bp_words got=%0d want=8", dataQ.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(10 + i)) begin
                errors++;
                $display("[TB] FAIL bp_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(10 + i));
            end
        end
        checks++; if (rdAddrQ.size() !== 8) begin errors++; $display("[TB] FAIL bp_reads got=%0d want=8", rdAddrQ.size()); end
        checks++; if (stableViol !== 0) begin errors++; $display("[TB] FAIL bp_stable got=%0d want=0", stableViol); end
        checks++; if (bufViol !== 0) begin errors++; $display("[TB] FAIL bp_buffer got=%0d want=0", bufViol); end
        checks++; if (doneCycle !== 27) begin errors++; $display("[TB] FAIL bp_done got=%0d want=27", doneCycle); end
    endtask

    task automatic test_edge_counts();
        runStream(5'd9, 6'd0, 0, 0, 20);
        checks++; if (rdAddrQ.size() !== 0) begin errors++; $display("[TB] FAIL zero_reads got=%0d want=0", rdAddrQ.size()); end
        checks++; if (doneCycle !== 1) begin errors++; $display("[TB] FAIL zero_done got=%0d want=1", doneCycle); end
        checks++; if (busyAt1 !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy got=%0b want=1", busyAt1); end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL zero_done_width got=%0d want=1", doneCount); end

        runStream(5'd7, 6'd32, 0, 0, 100);
        checks++; if (rdAddrQ.size() !== 32) begin errors++; $display("[TB] FAIL full_reads got=%0d want=32", rdAddrQ.size()); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(7 + i)) begin
                errors++;
                $display("[TB] FAIL full_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(7 + i));
            end
        end
        checks++; if (doneCycle !== 35) begin errors++; $display("[TB] FAIL full_done got=%0d want=35", doneCycle); end

        runStream(5'd0, 6'd5, 0, 2, 40);
        checks++; if (rdAddrQ.size() !== 5) begin errors++; $display("[TB] FAIL busy_start_reads got=%0d want=5", rdAddrQ.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(i)) begin
                errors++;
                $display("[TB] FAIL busy_start_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(i));
            end
        end
        checks++; if (doneCycle !== 8) begin errors++; $display("[TB] FAIL busy_start_done got=%0d want=8", doneCycle); end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_idle got=%0b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int hsCount = 0;
        @(negedge clk);
        start    = 1'b1;
        baseAddr = 5'd0;
        count    = 6'd10;
        outReady = 1'b1;
        for (int c = 1; c <= 40 && hsCount < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (bus.outValid && outReady) hsCount++;
        end
        checks++; if (hsCount !== 3) begin errors++; $display("[TB] FAIL mid_progress got=%0d want=3", hsCount); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got=%0b want=0", busy); end
        checks++; if (bus.rfRd !== 1'b0) begin errors++; $display("[TB] FAIL mid_rfRd got=%0b want=0", bus.rfRd); end
        checks++; if (bus.rfRdAddr !== '0) begin errors++; $display("[TB] FAIL mid_rfRdAddr got=%0d want=0", bus.rfRdAddr); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_outValid got=%0b want=0", bus.outValid); end
        checks++; if (bus.outData !== '0) begin errors++; $display("[TB] FAIL mid_outData got=%h want=0", bus.outData); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done got=%0b want=0", done); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        runStream(5'd0, 6'd2, 0, 0, 30);
        checks++; if (dataQ.size() !== 2) begin errors++; $display("[TB] FAIL after_words got=%0d want=2", dataQ.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(i)) begin
                errors++;
                $display("[TB] FAIL after_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(i));
            end
        end
        checks++; if (firstValid !== 2) begin errors++; $display("[TB] FAIL after_latency got=%0d want=2", firstValid); end
        checks++; if (doneCycle !== 5) begin errors++; $display("[TB] FAIL after_done got=%0d want=5", doneCycle); end
    endtask

`ifdef RF_READER_CLEAR_EN
    task automatic test_clear();
        preload();
        runStream(5'd8, 6'd4, 0, 0, 40);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= dataQ.size() || dataQ[i] !== expData(8 + i)) begin
                errors++;
                $display("[TB] FAIL clear_data%0d got=%h want=%h", i, (i < dataQ.size()) ? dataQ[i] : 'x, expData(8 + i));
            end
            checks++;
            if (rfMem[8 + i] !== '0) begin
                errors++;
                $display("[TB] FAIL clear_rf%0d got=%h want=0", 8 + i, rfMem[8 + i]);
            end
        end
        checks++; if (rfMem[12] !== 32'h10C) begin errors++; $display("[TB] FAIL clear_untouched got=%h want=10c", rfMem[12]); end
        checks++; if (rdAddrQ.size() !== 4) begin errors++; $display("[TB] FAIL clear_reads got=%0d want=4", rdAddrQ.size()); end
        checks++; if (wrtViol !== 0) begin errors++; $display("[TB] FAIL clear_wrt got=%0d want=0", wrtViol); end
    endtask
`endif

    initial begin
        test_reset();
        preload();
        test_basic();
        test_wrap();
        test_backpressure();
        test_edge_counts();
        test_reset_mid();
`ifdef RF_READER_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

endmodule
